// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES round sequencer.
// Holds widths, round counts, the controller state encoding, the S-box table
// and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned KEY_IDX_W = 4;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Forward S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 0x03 in GF(2^8).
  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Byte k of the block sits at [127-8k -: 8]; row r of column c is byte 4c+r.
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(15-(4*c+row)) +: 8] = s[8*(15-(4*((c+row)%4)+row)) +: 8];
      end
    end
    return r;
  endfunction

  // One MixColumns column; row 0 is the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
            gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One full AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey.
// Ports: state_i (current state), rk_i (round key), final_i (omit MixColumns),
//        state_o (next state).
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] rk_i,
  input  logic               final_i,
  output logic [BLOCK_W-1:0] state_o
);

  logic [BLOCK_W-1:0] sub_s;
  logic [BLOCK_W-1:0] shift_s;
  logic [BLOCK_W-1:0] mix_s;

  // SubBytes is position-independent, so byte order within the loop does not matter.
  for (genvar b = 0; b < 16; b++) begin : g_sbox
    assign sub_s[8*b +: 8] = sub_byte(state_i[8*b +: 8]);
  end

  assign shift_s = shift_rows(sub_s);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix_s[32*c +: 32] = mix_column(shift_s[32*c +: 32]);
  end

  assign state_o = (final_i ? shift_s : mix_s) ^ rk_i;

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES encryption sequencer: initial AddRoundKey on accept, then NR
// rounds through one shared round datapath, one per clock, then holds the
// ciphertext on a valid/ready port.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_block plaintext
//        port; key_idx/rk combinational key-store lookup; out_valid/out_ready/
//        out_block ciphertext port; busy (controller not idle).
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCK_W-1:0]   in_block,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [BLOCK_W-1:0]   rk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCK_W-1:0]   out_block,
  output logic                 busy
);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("aes_round_sched: NR must be 10, 12 or 14");
  end

  localparam logic [KEY_IDX_W-1:0] RND_LAST = KEY_IDX_W'(NR);

  state_e               state_q, state_d;
  logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
  logic [BLOCK_W-1:0]   st_q, st_d;
  logic [BLOCK_W-1:0]   round_out;
  logic                 final_rnd;

  assign final_rnd = (rnd_q == RND_LAST);

  aes_round u_round (
    .state_i (st_q),
    .rk_i    (rk),
    .final_i (final_rnd),
    .state_o (round_out)
  );

  // State register, round counter and cipher state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

  // Next-state logic; st_q only changes on accept and during rounds, so it
  // holds the ciphertext unchanged for the whole DONE stall.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d    = in_block ^ rk;
          rnd_d   = KEY_IDX_W'(1);
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        st_d = round_out;
        if (final_rnd) begin
          state_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + KEY_IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and key-index outputs decode from registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_block = st_q;
  assign key_idx   = (state_q == ST_ROUND) ? rnd_q : '0;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: an NR=10 instance driven through a scoreboard and
// an NR=14 instance checked against the AES-256 known answer.
module tb_aes_round_sched;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_block, rk, out_block;
  logic [3:0]   key_idx;
  logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0] in_block14, rk14_s, out_block14;
  logic [3:0]   key_idx14;

  logic [127:0] rk10 [16];
  logic [127:0] rk14 [16];
  logic [7:0]   sbox_m [256];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  logic [127:0] sb [$];
  int           acc_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational key stores.
  assign rk     = rk10[key_idx];
  assign rk14_s = rk14[key_idx14];

  aes_round_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .key_idx(key_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  aes_round_sched #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
    .in_block(in_block14), .key_idx(key_idx14), .rk(rk14_s), .out_valid(out_valid14),
    .out_ready(out_ready14), .out_block(out_block14), .busy(busy14)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the multiplicative inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input bit to14);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] val;
    int nr, nw;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      val = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      if (to14) rk14[r] = val;
      else      rk10[r] = val;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k, res;
    k = (nr == 14) ? rk14[0] : rk10[0];
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ k[127-8*b -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_m[s[b]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != nr) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      k = (nr == 14) ? rk14[r] : rk10[r];
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ k[127-8*b -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- scoreboard monitor (NR=10 instance) ----------------
  always @(negedge clk) begin
    logic [127:0] exp_blk;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(model_enc(in_block, 10));
        acc_cyc.push_back(cyc);
        n_acc = n_acc + 1;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_output got %h exp none", out_block);
        end else begin
          exp_blk = sb.pop_front();
          if (out_block !== exp_blk) begin
            n_fail++;
            $display("FAIL sb_ciphertext got %h exp %h", out_block, exp_blk);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_block !== 128'h0) begin n_fail++; $display("FAIL reset_out_block got %h exp 0", out_block); end
    n_tests++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL reset_key_idx got %0d exp 0", key_idx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_kat();
    out_ready = 1'b0;
    in_block  = PT;
    in_valid  = 1'b1;
    n_tests++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL kat_key_idx0 got %0d exp 0", key_idx); end
    tick();
    in_valid = 1'b0;
    in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 1; i <= 10; i++) begin
      n_tests++; if (key_idx !== 4'(i)) begin n_fail++; $display("FAIL kat_key_idx got %0d exp %0d", key_idx, i); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kat_early_valid round %0d got %b exp 0", i, out_valid); end
      tick();
    end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL kat_latency got out_valid %b exp 1", out_valid); end
    n_tests++; if (out_block !== CT128) begin n_fail++; $display("FAIL kat_ct got %h exp %h", out_block, CT128); end
    n_tests++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL kat_done_key_idx got %0d exp 0", key_idx); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL kat_return_idle got valid %b ready %b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    int  acc0;
    bit  ok;
    out_ready = 1'b0;
    in_block  = PT;
    in_valid  = 1'b1;
    tick();
    in_block = ~PT;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got no out_valid exp out_valid within 20"); end
    acc0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_block !== CT128) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got valid %b ready %b blk %h exp 1 0 %h", i, out_valid, in_ready, out_block, CT128);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got valid %b ready %b busy %b exp 0 1 0", out_valid, in_ready, busy); end
    n_tests++; if (n_acc !== acc0) begin n_fail++; $display("FAIL bp_second_accept got %0d exp %0d", n_acc, acc0); end
  endtask

  task automatic test_busy_ignored();
    int acc0;
    bit ok;
    acc0      = n_acc;
    out_ready = 1'b1;
    in_block  = PT;
    in_valid  = 1'b1;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        in_valid = 1'b0;
        ok = 1'b1;
        n_tests++; if (out_block !== CT128) begin n_fail++; $display("FAIL busy_ct got %h exp %h", out_block, CT128); end
        break;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_timeout got no out_valid exp out_valid within 20"); end
    in_valid = 1'b0;
    tick();
    n_tests++; if (n_acc !== acc0 + 1) begin n_fail++; $display("FAIL busy_accepts got %0d exp %0d", n_acc - acc0, 1); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blocks [3];
    int idx, acc0, c0;
    blocks[0] = PT;
    blocks[1] = 128'h0;
    blocks[2] = {128{1'b1}};
    idx  = 0;
    acc0 = n_acc;
    c0   = acc_cyc.size();
    out_ready = 1'b1;
    in_block  = blocks[0];
    in_valid  = 1'b1;
    for (int i = 0; i < 60 && idx < 3; i++) begin
      tick();
      if (n_acc - acc0 > idx) begin
        idx++;
        if (idx < 3) in_block = blocks[idx];
        else         in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 3", idx); end
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL b2b_drain got %0d pending exp 0", sb.size()); end
    if (acc_cyc.size() >= c0 + 3) begin
      for (int k = 1; k < 3; k++) begin
        n_tests++;
        if (acc_cyc[c0+k] - acc_cyc[c0+k-1] !== 12) begin
          n_fail++;
          $display("FAIL b2b_spacing got %0d exp 12", acc_cyc[c0+k] - acc_cyc[c0+k-1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    in_block  = PT;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (key_idx == 4'd5) begin ok = 1'b1; break; end
      tick();
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach_round5 got key_idx %0d exp 5", key_idx); end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_block !== 128'h0) begin n_fail++; $display("FAIL rstmid_out_block got %h exp 0", out_block); end
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || key_idx !== 4'd0) begin n_fail++; $display("FAIL rstmid_idle got ready %b busy %b key_idx %0d exp 1 0 0", in_ready, busy, key_idx); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    in_block = {128{1'b1}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout got no out_valid exp out_valid within 15"); end
    n_tests++; if (out_block !== model_enc({128{1'b1}}, 10)) begin n_fail++; $display("FAIL rstmid_ct got %h exp %h", out_block, model_enc({128{1'b1}}, 10)); end
    tick();
  endtask

  task automatic test_nr14();
    out_ready14 = 1'b0;
    in_block14  = PT;
    in_valid14  = 1'b1;
    tick();
    in_valid14 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      n_tests++;
      if (key_idx14 !== 4'(i) || out_valid14 !== 1'b0) begin
        n_fail++;
        $display("FAIL nr14_round got key_idx %0d valid %b exp %0d 0", key_idx14, out_valid14, i);
      end
      tick();
    end
    n_tests++; if (out_valid14 !== 1'b1) begin n_fail++; $display("FAIL nr14_latency got out_valid %b exp 1", out_valid14); end
    n_tests++; if (out_block14 !== CT256) begin n_fail++; $display("FAIL nr14_ct got %h exp %h", out_block14, CT256); end
    n_tests++; if (out_block14 !== model_enc(PT, 14)) begin n_fail++; $display("FAIL nr14_model got %h exp %h", out_block14, model_enc(PT, 14)); end
    out_ready14 = 1'b1;
    tick();
    n_tests++; if (busy14 !== 1'b0 || in_ready14 !== 1'b1) begin n_fail++; $display("FAIL nr14_idle got busy %b ready %b exp 0 1", busy14, in_ready14); end
  endtask

  initial begin
    in_valid    = 1'b0;
    in_block    = 128'h0;
    out_ready   = 1'b0;
    in_valid14  = 1'b0;
    in_block14  = 128'h0;
    out_ready14 = 1'b0;
    build_sbox();
    expand_key(KEY128, 4, 1'b0);
    expand_key(KEY256, 8, 1'b1);
    test_reset();
    test_kat();
    test_backpressure();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    test_nr14();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Iterative AES encryption round sequencer for the chaos crypto engine. It accepts one 128-bit block per transaction and fetches round keys by index from the external key store. It runs the initial AddRoundKey and then NR rounds through a single instantiated round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey), one round per clock. It then presents the ciphertext on a valid/ready output port. It sits between the chaos keystream/image-block front end and the AXI result path.

## Interface
- NR, default 10: round count. Legal values are 10, 12 and 14; any other value is an elaboration error.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  a plaintext block is offered.
- in_ready  out  1  the block accepts a plaintext this cycle.
- in_block  in  128  plaintext, FIPS-197 byte order (byte 0 = [127:120], column-major).
- key_idx  out  4  round-key index requested this cycle.
- rk  in  128  round key for key_idx, valid combinationally in the same cycle.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  downstream accepts the ciphertext.
- out_block  out  128  ciphertext, same byte order as in_block.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE: in_ready=1, key_idx=0.
    - On in_valid&&in_ready: st <= in_block ^ rk (initial AddRoundKey), rnd <= 1, go to ROUND.
  - ROUND: key_idx=rnd.
    - Each cycle: st <= round(st, rk, final = (rnd==NR)).
    - If rnd==NR, go to DONE; otherwise rnd <= rnd+1.
  - DONE: out_valid=1, out_block=st, key_idx=0.
    - On out_ready: go to IDLE.
    - While out_ready is low, st and out_block hold stable.
- Final round omits MixColumns; all other rounds apply it.
- in_ready is high only in IDLE. A new block is never accepted in DONE, even if out_ready is high in the same cycle.
- Inputs are ignored outside IDLE: in_valid while busy has no effect, and in_block may change freely.
- rnd is 4 bits and never exceeds NR; there is no wrap-around.
- Asynchronous reset mid-operation:
  - In-flight block discarded with no output produced.
  - st, rnd and out_block cleared to 0.
  - FSM goes to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, out_block=0, key_idx=0, busy=0.
- Latency: out_valid rises NR clock edges after the accepting edge (10 for AES-128). Breakdown: one accept edge performs AddRoundKey, then edges 1..NR perform the rounds.
- out_valid and out_block are registered; in_ready, key_idx and busy decode directly from FSM state and rnd (no combinational path from in_valid/out_ready).
- Best-case issue interval: NR+2 cycles per block with out_ready tied high (accept, NR rounds, DONE).
- rk is sampled on the same edge key_idx is presented. The key store must be combinational or otherwise meet single-cycle lookup.
- Critical path: st register → S-box → ShiftRows → MixColumns → XOR → st register.

## Structure
- Shared package aes_pkg holds:
  - FSM state encoding (IDLE, ROUND, DONE, 2 bits).
  - NR_128=10, NR_192=12, NR_256=14.
  - Block width 128 and key_idx width 4.
  - The xtime/GF(2^8) helper functions used by MixColumns.
- One sub-module, aes_round: purely combinational.
  - Inputs: state, round key, final flag.
  - Output: next state.
  - Internally instantiates the existing S-box and ShiftRows logic.
- The controller holds only the FSM, the rnd counter and the st register.

## Test plan
- Known answer, FIPS-197 C.1:
  - Stimulus: plaintext 00112233445566778899aabbccddeeff; bench key model expanded from key 000102030405060708090a0b0c0d0e0f.
  - Required: out_block = 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid exactly 10 edges after accept; key_idx sequence 0,1,…,10.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid rises.
  - Required: out_block stable; in_ready=0 throughout; no second acceptance; completes on the first out_ready=1 cycle; back in IDLE next cycle.
- Busy input ignored:
  - Stimulus: toggle in_valid with random in_block during ROUND.
  - Required: result still 69c4e0d8…c55a; exactly one transaction.
- Back-to-back:
  - Stimulus: in_valid and out_ready held high for 3 blocks (C.1 plaintext, all-zero, all-ones).
  - Required: ciphertexts match the reference model; acceptance edges spaced exactly 12 cycles apart.
- Reset mid-round:
  - Stimulus: drop rst_n asynchronously at round 5.
  - Required: out_valid=0, out_block=0, in_ready=1 immediately; next block encrypts correctly.
- NR=14 build:
  - Stimulus: FIPS-197 C.3 (key 000102…1f, same plaintext).
  - Required: 8ea2b7ca516745bfeafc49904b496089 after 14 edges.
